// File: rtl/cv32e40s_div_if.sv
// ============================================================================
//  Module      : cv32e40s_div_if
//  Description : EX-stage handshake bundle for the iterative divider
//                (operands, operator, halt/kill, valid/ready, result).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cv32e40s_div_if;
    logic        valid_i;
    logic [1:0]  operator_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic [31:0] result_o;
    logic        halt_i;
    logic        kill_i;
    logic        ready_o;
    logic        valid_o;
    logic        ready_i;

    // EX stage side: issues operations and consumes results
    modport master (
        output valid_i, operator_i, op_a_i, op_b_i, halt_i, kill_i, ready_i,
        input  result_o, ready_o, valid_o
    );

    // Divider side
    modport slave (
        input  valid_i, operator_i, op_a_i, op_b_i, halt_i, kill_i, ready_i,
        output result_o, ready_o, valid_o
    );
endinterface

`default_nettype wire

// File: rtl/cv32e40s_div.sv
// ============================================================================
//  Module      : cv32e40s_div
//  Description : Iterative radix-2 divider for DIV/DIVU/REM/REMU. Works on
//                operand magnitudes, one quotient bit per cycle, and fixes
//                the sign on the way out. Divide-by-zero retires in the
//                accept cycle without leaving the idle state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40s_div (
    input  wire logic           clk,
    input  wire logic           rst_n,
    cv32e40s_div_if.slave       bus
);

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_DIVIDE = 2'b01,
        DIV_FINISH = 2'b10
    } div_state_e;

    div_state_e  r_state;
    logic [31:0] r_rem;
    logic [31:0] r_q;
    logic [31:0] r_divisor;
    logic [4:0]  r_cnt;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_is_rem;

    logic        w_signed;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_b_zero;
    logic [32:0] w_rem_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_fin_result;
    logic        w_update;

    // Operand decode: signed ops work on magnitudes, sign fixed at the end.
    // The magnitude of 0x80000000 is 0x80000000 as an unsigned value, which
    // makes the overflow case fall out naturally.
    always_comb begin
        w_signed = ~bus.operator_i[0];
        w_a_mag  = (w_signed && bus.op_a_i[31]) ? (32'd0 - bus.op_a_i) : bus.op_a_i;
        w_b_mag  = (w_signed && bus.op_b_i[31]) ? (32'd0 - bus.op_b_i) : bus.op_b_i;
        w_b_zero = (bus.op_b_i == 32'd0);
    end

    // Restoring-division step. The partial remainder is always below the
    // divisor, so the 33-bit difference is negative exactly when the
    // shifted remainder is smaller than the divisor.
    always_comb begin
        w_rem_shift = {r_rem, r_q[31]};
        w_diff      = w_rem_shift - {1'b0, r_divisor};
        w_ge        = ~w_diff[32];
    end

    // Signed result selection in the finish state
    always_comb begin
        if (r_is_rem) begin
            w_fin_result = r_neg_r ? (32'd0 - r_rem) : r_rem;
        end else begin
            w_fin_result = r_neg_q ? (32'd0 - r_q) : r_q;
        end
    end

    assign w_update = (bus.valid_i && !bus.halt_i) || bus.kill_i;

    // Control FSM and datapath registers; kill wins over halt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= DIV_IDLE;
            r_rem     <= 32'd0;
            r_q       <= 32'd0;
            r_divisor <= 32'd0;
            r_cnt     <= 5'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_is_rem  <= 1'b0;
        end else if (w_update) begin
            if (bus.kill_i) begin
                r_state   <= DIV_IDLE;
                r_rem     <= 32'd0;
                r_q       <= 32'd0;
                r_divisor <= 32'd0;
                r_cnt     <= 5'd0;
                r_neg_q   <= 1'b0;
                r_neg_r   <= 1'b0;
                r_is_rem  <= 1'b0;
            end else begin
                case (r_state)
                    DIV_IDLE: begin
                        if (!w_b_zero) begin
                            r_q       <= w_a_mag;
                            r_divisor <= w_b_mag;
                            r_rem     <= 32'd0;
                            r_cnt     <= 5'd31;
                            r_neg_q   <= w_signed & (bus.op_a_i[31] ^ bus.op_b_i[31]);
                            r_neg_r   <= w_signed & bus.op_a_i[31];
                            r_is_rem  <= bus.operator_i[1];
                            r_state   <= DIV_DIVIDE;
                        end
                    end
                    DIV_DIVIDE: begin
                        r_rem <= w_ge ? w_diff[31:0] : w_rem_shift[31:0];
                        r_q   <= {r_q[30:0], w_ge};
                        r_cnt <= r_cnt - 5'd1;
                        if (r_cnt == 5'd0) begin
                            r_state <= DIV_FINISH;
                        end
                    end
                    DIV_FINISH: begin
                        if (bus.ready_i) begin
                            r_state <= DIV_IDLE;
                        end
                    end
                    default: begin
                        r_state <= DIV_IDLE;
                    end
                endcase
            end
        end
    end

    // Handshake outputs, then the valid/kill/halt overrides on top
    always_comb begin
        bus.valid_o  = 1'b0;
        bus.ready_o  = 1'b0;
        bus.result_o = 32'd0;
        case (r_state)
            DIV_IDLE: begin
                if (w_b_zero) begin
                    bus.valid_o  = 1'b1;
                    bus.ready_o  = bus.ready_i;
                    bus.result_o = bus.operator_i[1] ? bus.op_a_i : 32'hFFFF_FFFF;
                end
            end
            DIV_FINISH: begin
                bus.valid_o  = 1'b1;
                bus.ready_o  = bus.ready_i;
                bus.result_o = w_fin_result;
            end
            default: begin
                bus.valid_o = 1'b0;
                bus.ready_o = 1'b0;
            end
        endcase

        if (!bus.valid_i || bus.kill_i) begin
            bus.valid_o = 1'b0;
            bus.ready_o = 1'b1;
        end else if (bus.halt_i) begin
            bus.valid_o = 1'b0;
            bus.ready_o = 1'b0;
        end

        if (!rst_n) begin
            bus.valid_o = 1'b0;
            bus.ready_o = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cv32e40s_div.sv
// ============================================================================
//  Module      : tb_cv32e40s_div
//  Description : Scoreboard bench for cv32e40s_div with directed and random
//                operations checked against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cv32e40s_div;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cv32e40s_div_if bus();

    cv32e40s_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // RISC-V M-extension semantics in plain arithmetic
    function automatic logic [31:0] ref_model(input logic [1:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        case (op)
            OP_DIV: begin
                if (b == 32'd0)                                   r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else                                              r = $signed(a) / $signed(b);
            end
            OP_DIVU: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REM: begin
                if (b == 32'd0)                                   r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else                                              r = $signed(a) % $signed(b);
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Monitor: every retiring result is popped and compared
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.valid_o && bus.ready_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got %h, no result expected (cycle %0d)", bus.result_o, cyc);
            end else begin
                e = sb.pop_front();
                if (bus.result_o !== e.res) begin
                    errors++;
                    $display("FAIL result: got %h, expected %h (cycle %0d)", bus.result_o, e.res, cyc);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL latency: retired at cycle %0d, expected cycle %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; k is the cycle index relative to the accept cycle
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int halt_at, input int halt_len, input int bp);
        int          k;
        int          lat;
        int          ready_from;
        bit          done;
        bit          have;
        logic [31:0] held;
        exp_t        e;
        lat        = (b == 32'd0) ? 0 : 33 + halt_len;
        ready_from = (bp == 0) ? 0 : lat + bp;
        e.res      = ref_model(op, a, b);
        e.cyc      = cyc + ((ready_from > lat) ? ready_from : lat);
        sb.push_back(e);
        bus.valid_i    = 1'b1;
        bus.operator_i = op;
        bus.op_a_i     = a;
        bus.op_b_i     = b;
        k = 0; done = 1'b0; have = 1'b0; held = 32'd0;
        while (!done && k < 200) begin
            bus.halt_i  = (halt_len > 0) && (k >= halt_at) && (k < halt_at + halt_len);
            bus.ready_i = (k >= ready_from);
            if (k == 1 && b != 32'd0) begin
                bus.op_a_i     = $urandom;
                bus.op_b_i     = $urandom;
                bus.operator_i = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            if (bus.halt_i) begin
                checks++;
                if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL halt_outputs: valid_o=%b ready_o=%b, expected 0/0", bus.valid_o, bus.ready_o);
                end
            end
            if (bus.valid_o && !bus.ready_i) begin
                checks++;
                if (bus.ready_o !== 1'b0 || (have && bus.result_o !== held)) begin
                    errors++;
                    $display("FAIL backpressure_hold: ready_o=%b result_o=%h, expected 0 and %h",
                             bus.ready_o, bus.result_o, have ? held : bus.result_o);
                end
                held = bus.result_o;
                have = 1'b1;
            end
            done = bus.valid_o && bus.ready_o;
            step();
            k++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: op %0d a=%h b=%h did not retire within 200 cycles", op, a, b);
            sb.delete();
        end
        bus.valid_i = 1'b0;
        bus.halt_i  = 1'b0;
        bus.ready_i = 1'b1;
        step();
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          hl;

        // Reset: outputs must be quiet even with a div-by-zero presented
        bus.valid_i    = 1'b1;
        bus.operator_i = OP_DIVU;
        bus.op_a_i     = 32'h1234;
        bus.op_b_i     = 32'd0;
        bus.halt_i     = 1'b0;
        bus.kill_i     = 1'b0;
        bus.ready_i    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: valid_o=%b ready_o=%b, expected 0/1", bus.valid_o, bus.ready_o);
        end
        bus.valid_i = 1'b0;
        rst_n = 1'b1;
        step();

        // Directed cases
        run_op(OP_DIVU, 32'd100, 32'd7, 0, 0, 0);
        run_op(OP_REMU, 32'd100, 32'd7, 0, 0, 0);
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 0, 0, 0);
        run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 0, 0, 0);
        run_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, 0, 0, 0);
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        run_op(OP_DIVU, 32'h1234, 32'd0, 0, 0, 0);
        run_op(OP_REM,  32'h1234, 32'd0, 0, 0, 0);
        run_op(OP_DIVU, 32'd12345, 32'd11, 5, 5, 0);
        run_op(OP_REMU, 32'd12345, 32'd11, 0, 0, 4);
        run_op(OP_DIVU, 32'h1234, 32'd0, 0, 0, 2);

        // Kill during iteration 10, then a fresh operation
        bus.valid_i    = 1'b1;
        bus.operator_i = OP_DIVU;
        bus.op_a_i     = 32'd1000;
        bus.op_b_i     = 32'd3;
        for (int k = 0; k < 10; k++) step();
        bus.kill_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL kill_outputs: valid_o=%b ready_o=%b, expected 0/1", bus.valid_o, bus.ready_o);
        end
        step();
        bus.kill_i  = 1'b0;
        bus.valid_i = 1'b0;
        step();
        run_op(OP_DIVU, 32'd50, 32'd5, 0, 0, 0);

        // Asynchronous reset in the middle of a divide
        bus.valid_i    = 1'b1;
        bus.operator_i = OP_DIVU;
        bus.op_a_i     = 32'hFFFF_FFFF;
        bus.op_b_i     = 32'd1;
        for (int k = 0; k < 15; k++) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: valid_o=%b ready_o=%b, expected 0/1", bus.valid_o, bus.ready_o);
        end
        step();
        bus.valid_i = 1'b0;
        rst_n = 1'b1;
        step();
        run_op(OP_REMU, 32'd99, 32'd10, 0, 0, 0);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 16));
                3:       rb = -32'($urandom_range(1, 16));
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            hl = (rb != 32'd0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run_op(2'($urandom_range(0, 3)), ra, rb, $urandom_range(2, 20), hl,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_results: %0d results never retired, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 500000 time units");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
